// File: rtl/mem_arbiter.sv
// mem_arbiter: serializes split instruction/data requests onto a single
// physical memory port. A granted request is captured and replayed on pmem_*
// until pmem_resp, then the response is steered back to the owning client.
// Every completion returns to IDLE for one cycle before the next grant.
// Optional build macro ARB_ROUND_ROBIN_EN: on simultaneous requests, grant
// the client that was not granted last; otherwise data has fixed priority.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inst_read,
  input  logic [ADDR_WIDTH-1:0]   inst_addr,
  output logic                    inst_resp,
  output logic [DATA_WIDTH-1:0]   inst_rdata,
  input  logic                    data_read,
  input  logic                    data_write,
  input  logic [DATA_WIDTH/8-1:0] data_mbe,
  input  logic [ADDR_WIDTH-1:0]   data_addr,
  input  logic [DATA_WIDTH-1:0]   data_wdata,
  output logic                    data_resp,
  output logic [DATA_WIDTH-1:0]   data_rdata,
  output logic                    pmem_read,
  output logic                    pmem_write,
  output logic [DATA_WIDTH/8-1:0] pmem_mbe,
  output logic [ADDR_WIDTH-1:0]   pmem_addr,
  output logic [DATA_WIDTH-1:0]   pmem_wdata,
  input  logic [DATA_WIDTH-1:0]   pmem_rdata,
  input  logic                    pmem_resp
);

  localparam int MBE_WIDTH = DATA_WIDTH / 8;

  // state   | meaning
  // IDLE    | no transaction; requests sampled, arbitration on next edge
  // SERVE_I | instruction fetch on pmem, waiting for pmem_resp
  // SERVE_D | data load/store on pmem, waiting for pmem_resp
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [MBE_WIDTH-1:0]  mbe_q, mbe_d;
  logic                  write_q, write_d;

  logic data_req;
  logic grant_data;
  logic grant_inst;

  assign data_req = data_read | data_write;

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic GRANT_INST = 1'b0;
  localparam logic GRANT_DATA = 1'b1;

  logic last_grant_q, last_grant_d;

  // Arbitration: alternate on contention, otherwise serve whoever asks.
  always_comb begin
    grant_data = 1'b0;
    grant_inst = 1'b0;
    if (state_q == IDLE) begin
      if (data_req && inst_read) begin
        grant_data = (last_grant_q == GRANT_INST);
        grant_inst = (last_grant_q == GRANT_DATA);
      end else begin
        grant_data = data_req;
        grant_inst = inst_read;
      end
    end
  end

  // Remember which client won the most recent grant.
  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_data) begin
      last_grant_d = GRANT_DATA;
    end else if (grant_inst) begin
      last_grant_d = GRANT_INST;
    end
  end

  // Last-grant register; reset favours data on the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= GRANT_INST;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  // Arbitration: data always wins on contention.
  always_comb begin
    grant_data = 1'b0;
    grant_inst = 1'b0;
    if (state_q == IDLE) begin
      grant_data = data_req;
      grant_inst = inst_read & ~data_req;
    end
  end
`endif

  // Next state and request capture on the IDLE->SERVE edge.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mbe_d   = mbe_q;
    write_d = write_q;
    case (state_q)
      IDLE: begin
        if (grant_data) begin
          state_d = SERVE_D;
          addr_d  = data_addr;
          wdata_d = data_wdata;
          mbe_d   = data_mbe;
          // read+write together is treated as a write
          write_d = data_write;
        end else if (grant_inst) begin
          state_d = SERVE_I;
          addr_d  = inst_addr;
          wdata_d = '0;
          mbe_d   = '1;
          write_d = 1'b0;
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and captured-request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      mbe_q   <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mbe_q   <= mbe_d;
      write_q <= write_d;
    end
  end

  // Strobes decode straight from state so reset drops them without a clock.
  assign pmem_read  = (state_q == SERVE_I) | ((state_q == SERVE_D) & ~write_q);
  assign pmem_write = (state_q == SERVE_D) & write_q;
  assign pmem_addr  = addr_q;
  assign pmem_wdata = wdata_q;
  assign pmem_mbe   = mbe_q;

  assign inst_resp  = (state_q == SERVE_I) & pmem_resp;
  assign data_resp  = (state_q == SERVE_D) & pmem_resp;
  assign inst_rdata = inst_resp ? pmem_rdata : '0;
  assign data_rdata = data_resp ? pmem_rdata : '0;

endmodule
